// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants, types and helpers for the RV32I pipeline
package pipeline_pkg;

    // Load/store funct3 encodings (size in [1:0], zero-extend flag in [2])
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2
    } resultsrc_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   is_misaligned = addr_lo[0];
            2'b10:   is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the loaded byte/half lane and sign/zero-extends it
module load_extend
    import pipeline_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the 32-bit read word
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend the selected lane according to the load flavour
    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage data-memory access FSM plus MEM/WB pipeline register
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] aluresultM_i,
    input  logic [31:0] writedataM_i,
    input  logic [4:0]  rdM_i,
    input  logic [31:0] pcplus4M_i,
    input  logic [2:0]  funct3M_i,
    input  logic        memreadM_i,
    input  logic        memwriteM_i,
    input  logic        regwriteM_i,
    input  logic [1:0]  resultsrcM_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        stallM_o,
    output logic        misalignM_o,
    output logic        faultM_o,
    output logic [31:0] readdataW_o,
    output logic [31:0] aluresultW_o,
    output logic [31:0] pcplus4W_o,
    output logic [4:0]  rdW_o,
    output logic        regwriteW_o,
    output logic [1:0]  resultsrcW_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    logic        access;
    logic        misaligned;
    logic        aligned_access;
    logic        in_idle;
    logic        in_wait;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    logic [31:0] readdataW_q;
    logic [31:0] aluresultW_q;
    logic [31:0] pcplus4W_q;
    logic [4:0]  rdW_q;
    logic        regwriteW_q;
    logic [1:0]  resultsrcW_q;

    // State qualifiers are gated by rst_i so the request drops the instant reset rises
    assign access         = memreadM_i | memwriteM_i;
    assign misaligned     = access && is_misaligned(funct3M_i, aluresultM_i[1:0]);
    assign aligned_access = access && !misaligned;
    assign in_idle        = !rst_i && (state_q == IDLE);
    assign in_wait        = !rst_i && (state_q == WAIT);
    assign timeout_hit    = in_wait && !dmem_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // The abandoned (timed-out) cycle releases the stall so the pipeline moves on
    assign dmem_req_o  = (in_idle && aligned_access) || in_wait;
    assign stallM_o    = dmem_req_o && !dmem_ack_i && !timeout_hit;
    assign misalignM_o = in_idle && misaligned;
    assign faultM_o    = timeout_hit;

    // Byte-enable mask and lane-replicated store data from access size and offset
    always_comb begin
        case (funct3M_i)
            F3_SB, F3_LBU: begin
                lane_be    = 4'b0001 << aluresultM_i[1:0];
                lane_wdata = {4{writedataM_i[7:0]}};
            end
            F3_SH, F3_LHU: begin
                lane_be    = 4'b0011 << aluresultM_i[1:0];
                lane_wdata = {2{writedataM_i[15:0]}};
            end
            F3_SW: begin
                lane_be    = 4'b1111;
                lane_wdata = writedataM_i;
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = writedataM_i;
            end
        endcase
    end

    assign dmem_we_o    = dmem_req_o && memwriteM_i;
    assign dmem_addr_o  = dmem_req_o ? {aluresultM_i[31:2], 2'b00} : 32'd0;
    assign dmem_be_o    = dmem_req_o ? lane_be : 4'b0000;
    assign dmem_wdata_o = dmem_we_o ? lane_wdata : 32'd0;

    load_extend u_load_extend (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (aluresultM_i[1:0]),
        .funct3_i  (funct3M_i),
        .data_o    (load_data)
    );

    // Access FSM: wait for ack, count wait cycles, abandon on timeout
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (aligned_access && !dmem_ack_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_ack_i || timeout_hit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled or on a dropped access, else capture M values
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            readdataW_q  <= 32'd0;
            aluresultW_q <= 32'd0;
            pcplus4W_q   <= 32'd0;
            rdW_q        <= 5'd0;
            regwriteW_q  <= 1'b0;
            resultsrcW_q <= 2'd0;
        end else if (stallM_o || misalignM_o || faultM_o) begin
            regwriteW_q <= 1'b0;
        end else begin
            readdataW_q  <= load_data;
            aluresultW_q <= aluresultM_i;
            pcplus4W_q   <= pcplus4M_i;
            rdW_q        <= rdM_i;
            regwriteW_q  <= regwriteM_i;
            resultsrcW_q <= resultsrcM_i;
        end
    end

    assign readdataW_o  = readdataW_q;
    assign aluresultW_o = aluresultW_q;
    assign pcplus4W_o   = pcplus4W_q;
    assign rdW_o        = rdW_q;
    assign regwriteW_o  = regwriteW_q;
    assign resultsrcW_o = resultsrcW_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] aluresultM_i, writedataM_i, pcplus4M_i, dmem_rdata_i;
    logic [4:0]  rdM_i;
    logic [2:0]  funct3M_i;
    logic        memreadM_i, memwriteM_i, regwriteM_i, dmem_ack_i;
    logic [1:0]  resultsrcM_i;
    logic        dmem_req_o, dmem_we_o, stallM_o, misalignM_o, faultM_o, regwriteW_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, readdataW_o, aluresultW_o, pcplus4W_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  rdW_o;
    logic [1:0]  resultsrcW_o;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aluresultM_i(aluresultM_i), .writedataM_i(writedataM_i), .rdM_i(rdM_i),
        .pcplus4M_i(pcplus4M_i), .funct3M_i(funct3M_i), .memreadM_i(memreadM_i),
        .memwriteM_i(memwriteM_i), .regwriteM_i(regwriteM_i), .resultsrcM_i(resultsrcM_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ack_i(dmem_ack_i), .stallM_o(stallM_o), .misalignM_o(misalignM_o),
        .faultM_o(faultM_o), .readdataW_o(readdataW_o), .aluresultW_o(aluresultW_o),
        .pcplus4W_o(pcplus4W_o), .rdW_o(rdW_o), .regwriteW_o(regwriteW_o),
        .resultsrcW_o(resultsrcW_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Observations recorded by drive_op
    logic        o_req0, o_we0, o_mis, o_fault, o_bad_rw, o_expired;
    logic [31:0] o_addr0, o_wdata0, o_readdata, o_alu, o_pc4;
    logic [3:0]  o_be0;
    logic [4:0]  o_rd;
    logic        o_rw;
    logic [1:0]  o_rs;
    int          o_stalls, o_fault_k;

    // Reference: load extension from plain arithmetic on the lane value
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
        longint v;
        longint off;
        off = longint'(addr % 4);
        case (f3)
            3'd0, 3'd4: begin
                v = longint'(rdata >> (8 * off)) % 256;
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = longint'(rdata >> (8 * off)) % 65536;
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rdata);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int nbytes;
        int m;
        nbytes = 1 << f3[1:0];
        m = ((1 << nbytes) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return (wd % 256) * 32'h01010101;
        if (f3[1:0] == 2'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // Presents one M-stage instruction and plays the memory side; ack_after<0 never acks
    task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                            input logic rw, input logic [1:0] rs, input logic [31:0] pc4,
                            input int ack_after, input logic [31:0] rdata);
        logic stalled;
        logic done;
        memreadM_i = rd_en; memwriteM_i = wr_en; funct3M_i = f3; aluresultM_i = addr;
        writedataM_i = wd; rdM_i = rd; regwriteM_i = rw; resultsrcM_i = rs; pcplus4M_i = pc4;
        dmem_ack_i = 1'b0;
        o_mis = 0; o_fault = 0; o_bad_rw = 0; o_expired = 0; o_stalls = 0; o_fault_k = -1;
        done = 0;
        for (int k = 0; k < 40; k++) begin
            #2;
            dmem_ack_i = (k == ack_after);
            dmem_rdata_i = rdata;
            #2;
            if (k == 0) begin
                o_req0 = dmem_req_o; o_we0 = dmem_we_o; o_addr0 = dmem_addr_o;
                o_be0 = dmem_be_o; o_wdata0 = dmem_wdata_o;
            end
            if (misalignM_o) o_mis = 1;
            if (faultM_o) begin o_fault = 1; o_fault_k = k; end
            stalled = stallM_o;
            if (stalled) o_stalls++;
            @(posedge clk_i); #1;
            if (stalled && regwriteW_o !== 1'b0) o_bad_rw = 1;
            if (!stalled) begin done = 1; break; end
        end
        if (!done) o_expired = 1;
        dmem_ack_i = 1'b0;
        o_readdata = readdataW_o; o_alu = aluresultW_o; o_pc4 = pcplus4W_o;
        o_rd = rdW_o; o_rw = regwriteW_o; o_rs = resultsrcW_o;
    endtask

    task automatic test_reset();
        memreadM_i = 1; memwriteM_i = 0; funct3M_i = 3'd2; aluresultM_i = 32'h40;
        regwriteM_i = 1; dmem_ack_i = 0;
        #2;
        checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", dmem_req_o); end
        checks++; if (stallM_o !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", stallM_o); end
        checks++; if ({dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, misalignM_o, faultM_o} !== '0) begin
            failures++; $display("FAIL reset_dmem we=%b be=%h addr=%h wdata=%h want all 0", dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o); end
        checks++; if ({readdataW_o, aluresultW_o, pcplus4W_o, rdW_o, regwriteW_o, resultsrcW_o} !== '0) begin
            failures++; $display("FAIL reset_w rd=%h alu=%h pc4=%h want all 0", readdataW_o, aluresultW_o, pcplus4W_o); end
    endtask

    task automatic test_loads();
        drive_op(1, 0, 3'd2, 32'h100, 0, 5'd3, 1, 2'd1, 32'h204, 0, 32'hDEADBEEF);
        checks++; if (o_stalls !== 0) begin failures++; $display("FAIL lw_nostall got %0d want 0", o_stalls); end
        checks++; if (o_req0 !== 1'b1 || o_addr0 !== 32'h100) begin failures++; $display("FAIL lw_req got %b/%h want 1/00000100", o_req0, o_addr0); end
        checks++; if (o_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got %h want deadbeef", o_readdata); end
        checks++; if (o_rw !== 1'b1 || o_rd !== 5'd3 || o_rs !== 2'd1 || o_pc4 !== 32'h204) begin
            failures++; $display("FAIL lw_wfields got rw=%b rd=%0d rs=%0d pc4=%h want 1/3/1/00000204", o_rw, o_rd, o_rs, o_pc4); end
        drive_op(1, 0, 3'd0, 32'h103, 0, 5'd4, 1, 2'd1, 32'h208, 0, 32'h80FF0011);
        checks++; if (o_readdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got %h want ffffff80", o_readdata); end
        drive_op(1, 0, 3'd4, 32'h103, 0, 5'd5, 1, 2'd1, 32'h20C, 0, 32'h80FF0011);
        checks++; if (o_readdata !== 32'h00000080) begin failures++; $display("FAIL lbu_data got %h want 00000080", o_readdata); end
    endtask

    task automatic test_store_wait();
        drive_op(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 5'd0, 0, 2'd0, 32'h210, 3, 0);
        checks++; if (o_be0 !== 4'b1100) begin failures++; $display("FAIL sh_be got %b want 1100", o_be0); end
        checks++; if (o_wdata0 !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got %h want abcdabcd", o_wdata0); end
        checks++; if (o_we0 !== 1'b1 || o_addr0 !== 32'h100) begin failures++; $display("FAIL sh_we got %b/%h want 1/00000100", o_we0, o_addr0); end
        checks++; if (o_stalls !== 3) begin failures++; $display("FAIL sh_stalls got %0d want 3", o_stalls); end
        checks++; if (o_bad_rw !== 1'b0) begin failures++; $display("FAIL sh_rw_in_stall got %b want 0", o_bad_rw); end
    endtask

    task automatic test_misalign();
        drive_op(1, 0, 3'd2, 32'h101, 0, 5'd7, 1, 2'd1, 32'h214, -1, 32'h11111111);
        checks++; if (o_req0 !== 1'b0) begin failures++; $display("FAIL mis_req got %b want 0", o_req0); end
        checks++; if (o_mis !== 1'b1) begin failures++; $display("FAIL mis_pulse got %b want 1", o_mis); end
        checks++; if (o_stalls !== 0) begin failures++; $display("FAIL mis_stall got %0d want 0", o_stalls); end
        checks++; if (o_rw !== 1'b0) begin failures++; $display("FAIL mis_rw got %b want 0", o_rw); end
    endtask

    task automatic test_timeout();
        drive_op(1, 0, 3'd2, 32'h200, 0, 5'd9, 1, 2'd1, 32'h218, -1, 0);
        checks++; if (o_stalls !== TO) begin failures++; $display("FAIL to_stalls got %0d want %0d", o_stalls, TO); end
        checks++; if (o_fault !== 1'b1 || o_fault_k !== TO) begin failures++; $display("FAIL to_fault got %b@%0d want 1@%0d", o_fault, o_fault_k, TO); end
        checks++; if (o_rw !== 1'b0 || o_expired !== 1'b0) begin failures++; $display("FAIL to_bubble got rw=%b exp=%b want 0/0", o_rw, o_expired); end
        drive_op(0, 0, 3'd0, 32'h55, 0, 5'd10, 1, 2'd0, 32'h21C, -1, 0);
        checks++; if (o_stalls !== 0 || o_rw !== 1'b1 || o_alu !== 32'h55) begin
            failures++; $display("FAIL to_idle_after got stalls=%0d rw=%b alu=%h want 0/1/00000055", o_stalls, o_rw, o_alu); end
    endtask

    task automatic test_reset_in_wait();
        memreadM_i = 1; memwriteM_i = 0; funct3M_i = 3'd2; aluresultM_i = 32'h300;
        regwriteM_i = 1; rdM_i = 5'd12; pcplus4M_i = 32'h300; dmem_ack_i = 0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #3;
        checks++; if (dmem_req_o !== 1'b1 || stallM_o !== 1'b1) begin failures++; $display("FAIL rw_pre got req=%b stall=%b want 1/1", dmem_req_o, stallM_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (dmem_req_o !== 1'b0 || stallM_o !== 1'b0) begin failures++; $display("FAIL rw_drop got req=%b stall=%b want 0/0", dmem_req_o, stallM_o); end
        checks++; if ({readdataW_o, aluresultW_o, pcplus4W_o, rdW_o, regwriteW_o, resultsrcW_o} !== '0) begin
            failures++; $display("FAIL rw_wzero alu=%h pc4=%h rd=%0d want 0", aluresultW_o, pcplus4W_o, rdW_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0; memreadM_i = 0; regwriteM_i = 0; dmem_ack_i = 1'b1;
        #3;
        checks++; if (dmem_req_o !== 1'b0 || stallM_o !== 1'b0) begin failures++; $display("FAIL rw_late_ack got req=%b stall=%b want 0/0", dmem_req_o, stallM_o); end
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        drive_op(1, 0, 3'd2, 32'h304, 0, 5'd13, 1, 2'd1, 32'h308, 0, 32'hCAFEF00D);
        checks++; if (o_stalls !== 0 || o_readdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL rw_after got stalls=%0d data=%h want 0/cafef00d", o_stalls, o_readdata); end
    endtask

    task automatic test_random();
        int kind, waits, nbytes;
        logic rd_en, wr_en, rw, mis, acc;
        logic [2:0] f3;
        logic [31:0] addr, wd, rdata, pc4;
        logic [4:0] rd;
        logic [1:0] rs;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            rd_en = (kind == 0); wr_en = (kind == 1);
            case (kind)
                0: begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                    endcase
                    rs = 2'd1;
                end
                1: begin f3 = 3'($urandom_range(0, 2)); rs = 2'd0; end
                default: begin f3 = 3'($urandom_range(0, 7)); rs = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd0; end
            endcase
            addr = $urandom; wd = $urandom; rdata = $urandom; pc4 = $urandom;
            rd = 5'($urandom); rw = 1'($urandom); waits = $urandom_range(0, 4);
            acc = rd_en | wr_en;
            nbytes = 1 << f3[1:0];
            mis = acc && ((addr % nbytes) != 0);
            drive_op(rd_en, wr_en, f3, addr, wd, rd, rw, rs, pc4, waits, rdata);
            checks++; if (o_expired !== 1'b0 || o_fault !== 1'b0 || o_bad_rw !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_flags got exp=%b fault=%b badrw=%b want 0/0/0", n, o_expired, o_fault, o_bad_rw); end
            checks++; if (o_stalls !== ((acc && !mis) ? waits : 0)) begin
                failures++; $display("FAIL rnd%0d_stalls got %0d want %0d", n, o_stalls, (acc && !mis) ? waits : 0); end
            checks++; if (o_req0 !== (acc && !mis) || o_mis !== mis) begin
                failures++; $display("FAIL rnd%0d_req got req=%b mis=%b want %b/%b", n, o_req0, o_mis, acc && !mis, mis); end
            checks++; if (o_rw !== (rw && !mis)) begin failures++; $display("FAIL rnd%0d_rw got %b want %b", n, o_rw, rw && !mis); end
            if (!mis) begin
                checks++; if (o_rd !== rd || o_alu !== addr || o_pc4 !== pc4 || o_rs !== rs) begin
                    failures++; $display("FAIL rnd%0d_wfields got rd=%0d alu=%h pc4=%h rs=%0d want %0d/%h/%h/%0d", n, o_rd, o_alu, o_pc4, o_rs, rd, addr, pc4, rs); end
            end
            if (rd_en && !mis) begin
                checks++; if (o_readdata !== ref_load(rdata, addr, f3)) begin
                    failures++; $display("FAIL rnd%0d_load got %h want %h", n, o_readdata, ref_load(rdata, addr, f3)); end
            end
            if (wr_en && !mis) begin
                checks++; if (o_we0 !== 1'b1 || o_be0 !== ref_be(f3, addr) || o_wdata0 !== ref_wdata(f3, wd) || o_addr0 !== {addr[31:2], 2'b00}) begin
                    failures++; $display("FAIL rnd%0d_store got we=%b be=%b wd=%h a=%h want 1/%b/%h/%h", n, o_we0, o_be0, o_wdata0, o_addr0, ref_be(f3, addr), ref_wdata(f3, wd), {addr[31:2], 2'b00}); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0;
        memreadM_i = 0; memwriteM_i = 0; regwriteM_i = 0; funct3M_i = 0; aluresultM_i = 0;
        writedataM_i = 0; rdM_i = 0; pcplus4M_i = 0; resultsrcM_i = 0;
        dmem_rdata_i = 0; dmem_ack_i = 0;
        #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        test_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0; memreadM_i = 0; regwriteM_i = 0;
        test_loads();
        test_store_wait();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
